jt51_mixacc: RTL and testbench

- Consumes the 14-bit signed operator output stream, one slot per cen cycle, 32 slots per frame.
- Selects carrier operators according to each channel's connection algorithm.
- Sums the carriers into left and right accumulators using the channel pan bits.
- Emits one saturated 16-bit stereo sample per frame. It sits directly downstream of the operator pipeline and feeds the DAC/serial output stage.

---
 rtl/jt51_mix_pkg.sv | 33 +++
 rtl/jt51_mixacc_lane.sv | 42 ++++
 rtl/jt51_mixacc.sv | 78 +++++++
 tb/tb_jt51_mixacc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt51_mix_pkg.sv
// Shared definitions for the jt51 output mixer: slot-field operator codes,
// carrier decode per connection algorithm, and output saturation.
package jt51_mix_pkg;

  typedef enum logic [1:0] {
    OP_M1 = 2'd0,
    OP_M2 = 2'd1,
    OP_C1 = 2'd2,
    OP_C2 = 2'd3
  } op_e;

  localparam logic [4:0] SLOT_LAST = 5'd31;

  function automatic logic is_carrier(input logic [2:0] con, input op_e op);
    if (con == 3'd7) return 1'b1;
    if (con >= 3'd5) return op != OP_M1;
    if (con == 3'd4) return (op == OP_C1) || (op == OP_C2);
    return op == OP_C2;
  endfunction

  // Clamp a sign-extended accumulator value to the signed range of outw bits.
  function automatic logic signed [31:0] sat(input logic signed [31:0] acc,
                                             input int unsigned outw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (outw - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/jt51_mixacc_lane.sv
// One stereo side: per-frame accumulator and saturating output register.
module jt51_mixacc_lane
  import jt51_mix_pkg::*;
#(
  parameter int ACCW = 19,
  parameter int OUTW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   first,
  input  logic                   last,
  input  logic signed [ACCW-1:0] c,
  output logic signed [OUTW-1:0] q
);

  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] sum;
  logic signed [OUTW-1:0] q_next;

  always_comb begin
    sum    = acc + c;
    q_next = OUTW'(sat(32'(sum), OUTW));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      q   <= '0;
    end else if (cen) begin
      if (last) begin
        acc <= '0;
        q   <= q_next;
      end else if (first) begin
        acc <= c;
      end else begin
        acc <= sum;
      end
    end
  end

endmodule

// File: rtl/jt51_mixacc.sv
// Operator-stream mixer: selects carriers per channel algorithm, pans them into
// left/right accumulators and emits one saturated stereo sample per 32-slot frame.
module jt51_mixacc
  import jt51_mix_pkg::*;
#(
  parameter int OPW  = 14,
  parameter int ACCW = 19,
  parameter int OUTW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   zero,
  input  logic signed [OPW-1:0]  op_in,
  input  logic [2:0]             con_in,
  input  logic [1:0]             rl_in,
  output logic signed [OUTW-1:0] left,
  output logic signed [OUTW-1:0] right,
  output logic                   sample
);

  logic [4:0]             cnt;
  logic [4:0]             slot;
  logic                   first;
  logic                   last;
  logic                   carrier;
  logic signed [ACCW-1:0] op_ext;
  logic signed [ACCW-1:0] cl;
  logic signed [ACCW-1:0] cr;

  // zero overrides the counter, so a sync pulse on slot 31 never emits a sample.
  always_comb begin
    slot    = zero ? '0 : cnt;
    first   = (slot == '0);
    last    = (slot == SLOT_LAST);
    carrier = is_carrier(con_in, op_e'(slot[4:3]));
    op_ext  = {{(ACCW-OPW){op_in[OPW-1]}}, op_in};
    cl      = (carrier && rl_in[0]) ? op_ext : '0;
    cr      = (carrier && rl_in[1]) ? op_ext : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      sample <= 1'b0;
    end else begin
      sample <= cen && last;
      if (cen) cnt <= slot + 5'd1;
    end
  end

  jt51_mixacc_lane #(
    .ACCW(ACCW),
    .OUTW(OUTW)
  ) u_left (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .first(first),
    .last (last),
    .c    (cl),
    .q    (left)
  );

  jt51_mixacc_lane #(
    .ACCW(ACCW),
    .OUTW(OUTW)
  ) u_right (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .first(first),
    .last (last),
    .c    (cr),
    .q    (right)
  );

endmodule

// File: tb/tb_jt51_mixacc.sv
// Scoreboard bench for jt51_mixacc: frames are built as arrays, their expected
// stereo sample is computed from the carrier/pan rules and checked when sample fires.
module tb_jt51_mixacc;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cen = 1'b0;
  logic               zero = 1'b0;
  logic signed [13:0] op_in = '0;
  logic [2:0]         con_in = '0;
  logic [1:0]         rl_in = '0;
  logic signed [15:0] left;
  logic signed [15:0] right;
  logic               sample;

  int errors = 0;
  int checks = 0;
  int exp_l_q[$];
  int exp_r_q[$];
  int cur_l = 0;
  int cur_r = 0;
  int op_a[32];
  int con_a[8];
  int rl_a[8];
  bit prev_sample = 1'b0;

  jt51_mixacc #(
    .OPW (14),
    .ACCW(19),
    .OUTW(16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .zero  (zero),
    .op_in (op_in),
    .con_in(con_in),
    .rl_in (rl_in),
    .left  (left),
    .right (right),
    .sample(sample)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Operator index: 0=M1, 1=M2, 2=C1, 3=C2.
  function automatic bit carries(input int con, input int opn);
    case (con)
      0, 1, 2, 3: return opn == 3;
      4:          return opn >= 2;
      5, 6:       return opn >= 1;
      default:    return 1'b1;
    endcase
  endfunction

  task automatic frame_expect(output int el, output int er);
    el = 0;
    er = 0;
    for (int s = 0; s < 32; s++) begin
      if (carries(con_a[s % 8], s / 8)) begin
        if (rl_a[s % 8] % 2 == 1) el += op_a[s];
        if (rl_a[s % 8] >= 2)     er += op_a[s];
      end
    end
    el = clamp16(el);
    er = clamp16(er);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_random();
    cen    = 1'b0;
    zero   = 1'($urandom_range(0, 1));
    op_in  = 14'($urandom);
    con_in = 3'($urandom);
    rl_in  = 2'($urandom);
  endtask

  task automatic set_const(input int op, input int con, input int rl);
    for (int s = 0; s < 32; s++) op_a[s] = op;
    for (int c = 0; c < 8; c++) begin
      con_a[c] = con;
      rl_a[c]  = rl;
    end
  endtask

  task automatic set_random();
    for (int s = 0; s < 32; s++) begin
      case ($urandom_range(0, 7))
        0:       op_a[s] = 8191;
        1:       op_a[s] = -8192;
        default: op_a[s] = int'($urandom_range(0, 16383)) - 8192;
      endcase
    end
    for (int c = 0; c < 8; c++) begin
      con_a[c] = int'($urandom_range(0, 7));
      rl_a[c]  = int'($urandom_range(0, 3));
    end
  endtask

  // Drives nslots cen cycles from slot 0; slow inserts two cen=0 cycles per slot.
  task automatic run_frame(input bit use_zero, input bit slow, input bit expect_out,
                           input int nslots);
    int el;
    int er;
    el = 0;
    er = 0;
    if (expect_out) begin
      frame_expect(el, er);
      exp_l_q.push_back(el);
      exp_r_q.push_back(er);
    end
    for (int s = 0; s < nslots; s++) begin
      cen    = 1'b1;
      zero   = use_zero && (s == 0);
      op_in  = op_a[s][13:0];
      con_in = con_a[s % 8][2:0];
      rl_in  = rl_a[s % 8][1:0];
      tick();
      if (expect_out && s == 31) begin
        cur_l = el;
        cur_r = er;
      end
      if (slow) begin
        repeat (2) begin
          idle_random();
          tick();
          check("frozen_left", int'(left), cur_l);
          check("frozen_right", int'(right), cur_r);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    int el;
    int er;
    if (sample) begin
      check("strobe_width", int'(prev_sample), 0);
      if (exp_l_q.size() == 0) begin
        check("unexpected_sample", 1, 0);
      end else begin
        el = exp_l_q.pop_front();
        er = exp_r_q.pop_front();
        check("left", int'(left), el);
        check("right", int'(right), er);
      end
    end
    prev_sample = sample;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) begin
      cen   = 1'b1;
      zero  = 1'($urandom_range(0, 1));
      op_in = 14'($urandom);
      tick();
    end
    check("reset_left", int'(left), 0);
    check("reset_right", int'(right), 0);
    check("reset_sample", int'(sample), 0);
    rst = 1'b0;

    // Sum, carrier selection and mixed per-channel algorithms.
    set_const(100, 7, 3); run_frame(1, 0, 1, 32);
    set_const(100, 0, 3); run_frame(1, 0, 1, 32);
    set_const(100, 4, 3); run_frame(0, 0, 1, 32);
    set_const(100, 5, 3); run_frame(0, 0, 1, 32);
    set_const(100, 0, 3); con_a[0] = 7; run_frame(1, 0, 1, 32);

    // Panning.
    set_const(100, 7, 1); run_frame(1, 0, 1, 32);
    set_const(100, 7, 2); run_frame(1, 0, 1, 32);
    set_const(100, 7, 0); run_frame(1, 0, 1, 32);

    // Saturation limits and a small negative sum.
    set_const(8191, 7, 3);  run_frame(1, 0, 1, 32);
    set_const(-8192, 7, 3); run_frame(1, 0, 1, 32);
    set_const(-1, 7, 3);    run_frame(1, 0, 1, 32);

    // Realignment at count 12, and a sync pulse landing on slot 31.
    set_const(100, 7, 3);
    run_frame(1, 0, 0, 12);
    set_const(55, 7, 3);    run_frame(1, 0, 1, 32);
    run_frame(1, 0, 0, 31);
    set_const(-300, 7, 3);  run_frame(1, 0, 1, 32);

    // Sparse clock enable.
    set_const(100, 7, 3);   run_frame(1, 1, 1, 32);
    set_random();           run_frame(0, 1, 1, 32);

    for (int i = 0; i < 24; i++) begin
      set_random();
      run_frame((i % 3) == 0, 1'($urandom_range(0, 1)), 1, 32);
    end

    // Reset in the middle of a frame.
    set_const(100, 7, 3);
    run_frame(1, 0, 1, 32);
    run_frame(1, 0, 0, 20);
    rst   = 1'b1;
    cen   = 1'b1;
    op_in = 14'($urandom);
    tick();
    check("midreset_left", int'(left), 0);
    check("midreset_right", int'(right), 0);
    check("midreset_sample", int'(sample), 0);
    cur_l = 0;
    cur_r = 0;
    rst = 1'b0;
    set_random();
    run_frame(0, 0, 1, 32);

    cen = 1'b0;
    repeat (4) tick();
    check("pending_samples", exp_l_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
